input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning stable-input cycles needed to accept a level change (10 ms at 50 MHz); minimum legal value is 2.
REQ-002 The block SHALL have parameter N_BTN, default 4, meaning number of push-button channels.
REQ-003 The block SHALL have parameter N_SW, default 9, meaning number of slide-switch channels.
REQ-004 The block SHALL have port clk_50, input, 1, the single system clock; all logic is in this domain.
REQ-005 The block SHALL have port reset, input, 1, an asynchronous active-low reset (asserted at 0).
REQ-006 The block SHALL have port btn_raw, input, N_BTN, raw board keys, active-low (0 = pressed), asynchronous to clk_50.
REQ-007 The block SHALL have port sw_raw, input, N_SW, raw board switches, active-high, asynchronous to clk_50.
REQ-008 The block SHALL have port event_clr, input, N_BTN, per-button sticky-event clear, one-cycle pulses from software.
REQ-009 The block SHALL have port btn_level, output, N_BTN, debounced button state, active-high (1 = pressed); feeds the platform button PIO.
REQ-010 The block SHALL have port sw_level, output, N_SW, debounced switch state; feeds the platform switch PIO.
REQ-011 The block SHALL have port btn_press, output, N_BTN, one-cycle pulse per accepted press.
REQ-012 The block SHALL have port btn_event, output, N_BTN, sticky press flags.
REQ-013 The block SHALL have port sw_changed, output, 1, one-cycle pulse when any sw_level bit changes.

Function
REQ-014 Each raw input bit SHALL pass through a two-flop synchronizer before any other use; btn_raw SHALL be inverted after synchronization.
REQ-015 Each channel SHALL hold a stable value and a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-016 When a channel's synchronized value equals its stable value, its counter SHALL load 0.
REQ-017 When the synchronized value differs and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-018 When the synchronized value differs and the counter equals DEBOUNCE_CYCLES-1, the stable value SHALL take the synchronized value and the counter SHALL load 0.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL restart counting; the counter SHALL never wrap.
REQ-020 Latency: a raw change held steady SHALL appear on the level output at rising edge number DEBOUNCE_CYCLES+2, where edge 1 is the first edge that samples the new raw value.
REQ-021 btn_press[i] SHALL be 1 for exactly one cycle, in the same cycle btn_level[i] first reads 1 after a 0->1 transition; a release SHALL produce no pulse.
REQ-022 btn_event[i] SHALL set on btn_press[i] and clear on event_clr[i]; if both occur in the same cycle, set SHALL win.
REQ-023 sw_changed SHALL be 1 for exactly one cycle, in the same cycle any sw_level bit differs from its previous value; simultaneous changes on several bits SHALL produce one pulse.
REQ-024 Channels SHALL be fully independent; simultaneous transitions on all channels SHALL each be accepted on schedule.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-026 While reset=0, btn synchronizer flops SHALL hold 1 (released) and sw synchronizer flops SHALL hold 0.
REQ-027 While reset=0, all counters, stable values, btn_level, sw_level, btn_press, btn_event and sw_changed SHALL be 0.
REQ-028 Reset assertion mid-count SHALL discard the count; after release, a pressed key SHALL need a full DEBOUNCE_CYCLES+2 edges to be accepted.
REQ-029 Reset release SHALL never by itself produce btn_press or sw_changed.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 btn_raw[0] 1->0 held -> btn_level[0]=1 and btn_press[0] pulses at edge 6; btn_event[0]=1 from edge 6 onward.
REQ-031 btn_raw[1] 0 for 3 cycles then back to 1 (glitch) -> btn_level[1], btn_press[1] and btn_event[1] stay 0.
REQ-032 btn_event[2]=1, then event_clr[2] pulsed in the same cycle as a new btn_press[2] -> btn_event[2] remains 1; event_clr[2] alone on the next cycle -> 0.
REQ-033 sw_raw 0x000->0x1FF in one cycle -> sw_level=0x1FF at edge 6 with exactly one sw_changed pulse.
REQ-034 Key pressed, reset asserted at edge 3, released -> all outputs 0 during reset; btn_level=1 exactly 6 edges after release with the key still held, with one btn_press.
REQ-035 Key held pressed then released -> btn_level returns to 0 at edge 6 after release with no btn_press.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces raw board keys and switches.
//   clk_50     : system clock, every flop is in this domain
//   reset      : asynchronous reset, active low
//   btn_raw    : raw keys, active low, asynchronous
//   sw_raw     : raw switches, active high, asynchronous
//   event_clr  : per-button pulse that clears the sticky event flag
//   btn_level  : debounced key state, 1 = pressed
//   sw_level   : debounced switch state
//   btn_press  : one-cycle pulse on each accepted press
//   btn_event  : sticky press flags
//   sw_changed : one-cycle pulse when any debounced switch changes
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int N_BTN           = 4,
    parameter int N_SW            = 9
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] event_clr,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_event,
    output logic             sw_changed
);
    localparam int N  = N_BTN + N_SW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    // Synchronizers idle at the released/off level so leaving reset is quiet.
    localparam logic [N-1:0] SYNC_RST = {{N_SW{1'b0}}, {N_BTN{1'b1}}};

    logic [N-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N-1:0]          stable_q, stable_d;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [N_BTN-1:0]      press_q, press_d, event_q, event_d;
    logic                  sw_changed_q, sw_changed_d;
    logic [N-1:0]          cur;
    logic [N-1:0]          accept;

    always_comb begin
        sync1_d = {sw_raw, btn_raw};
        sync2_d = sync1_q;
        // Keys become active high once synchronized.
        cur     = {sync2_q[N-1:N_BTN], ~sync2_q[N_BTN-1:0]};
        accept  = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < N; i++) begin
            accept[i] = (cur[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX);
            cnt_d[i]  = (cur[i] == stable_q[i] || accept[i]) ? '0 : cnt_q[i] + CW'(1);
        end
        stable_d     = stable_q ^ accept;
        press_d      = accept[N_BTN-1:0] & cur[N_BTN-1:0];
        // Holding on press_q as well lets a clear that lands in the visible
        // press cycle lose to the set.
        event_d      = press_d | press_q | (event_q & ~event_clr);
        sw_changed_d = |accept[N-1:N_BTN];
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            sync1_q      <= SYNC_RST;
            sync2_q      <= SYNC_RST;
            stable_q     <= '0;
            cnt_q        <= '0;
            press_q      <= '0;
            event_q      <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
            event_q      <= event_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign btn_level  = stable_q[N_BTN-1:0];
    assign sw_level   = stable_q[N-1:N_BTN];
    assign btn_press  = press_q;
    assign btn_event  = event_q;
    assign sw_changed = sw_changed_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scoreboard bench for input_conditioner with a 4-cycle debounce.
module tb_input_conditioner;
    logic       clk_50 = 1'b0;
    logic       reset;
    logic [3:0] btn_raw, event_clr;
    logic [8:0] sw_raw;
    logic [3:0] btn_level, btn_press, btn_event;
    logic [8:0] sw_level;
    logic       sw_changed;

    typedef struct {
        string      tag;
        int         at;
        logic [3:0] bl, bp, be;
        logic [8:0] sl;
        logic       sc;
    } exp_t;

    exp_t q[$];
    int   e = 0;
    int   checks = 0;
    int   errors = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(4), .N_BTN(4), .N_SW(9)) dut (
        .clk_50(clk_50), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .event_clr(event_clr), .btn_level(btn_level), .sw_level(sw_level),
        .btn_press(btn_press), .btn_event(btn_event), .sw_changed(sw_changed)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s observed %h expected %h at edge %0d", tag, obs, ex, e);
        end
    endtask

    // Expectation d edges after the last completed edge.
    task automatic expect_at(input string tag, input int d, input logic [3:0] bl,
                             input logic [3:0] bp, input logic [3:0] be,
                             input logic [8:0] sl, input logic sc);
        exp_t x;
        x.tag = tag; x.at = e + d; x.bl = bl; x.bp = bp; x.be = be; x.sl = sl; x.sc = sc;
        q.push_back(x);
    endtask

    task automatic tick(input int n);
        exp_t x;
        repeat (n) begin
            @(posedge clk_50);
            e++;
            @(negedge clk_50);
            while (q.size() > 0 && q[0].at <= e) begin
                x = q.pop_front();
                chk({x.tag, "_timing"}, 9'(x.at), 9'(e));
                chk({x.tag, "_btn_level"}, 9'(btn_level), 9'(x.bl));
                chk({x.tag, "_btn_press"}, 9'(btn_press), 9'(x.bp));
                chk({x.tag, "_btn_event"}, 9'(btn_event), 9'(x.be));
                chk({x.tag, "_sw_level"}, sw_level, x.sl);
                chk({x.tag, "_sw_changed"}, 9'(sw_changed), 9'(x.sc));
            end
        end
    endtask

    initial begin
        reset = 1'b1; btn_raw = 4'hF; sw_raw = '0; event_clr = '0;
        #1 reset = 1'b0;
        expect_at("reset", 2, 4'h0, 4'h0, 4'h0, 9'h000, 1'b0);
        tick(2);
        reset = 1'b1;
        expect_at("idle", 6, 4'h0, 4'h0, 4'h0, 9'h000, 1'b0);
        tick(6);
        // Press key 0 and hold.
        btn_raw = 4'b1110;
        expect_at("press0_pre", 5, 4'h0, 4'h0, 4'h0, 9'h000, 1'b0);
        expect_at("press0", 6, 4'h1, 4'h1, 4'h1, 9'h000, 1'b0);
        expect_at("press0_post", 7, 4'h1, 4'h0, 4'h1, 9'h000, 1'b0);
        tick(7);
        // Three-cycle glitch on key 1 must be rejected.
        btn_raw = 4'b1100;
        expect_at("glitch1_a", 6, 4'h1, 4'h0, 4'h1, 9'h000, 1'b0);
        expect_at("glitch1_b", 8, 4'h1, 4'h0, 4'h1, 9'h000, 1'b0);
        tick(3);
        btn_raw = 4'b1110;
        tick(5);
        // Key 2: press, release, press again with a clear in the press cycle.
        btn_raw = 4'b1010;
        expect_at("press2", 6, 4'h5, 4'h4, 4'h5, 9'h000, 1'b0);
        tick(6);
        btn_raw = 4'b1110;
        expect_at("release2", 6, 4'h1, 4'h0, 4'h5, 9'h000, 1'b0);
        tick(6);
        btn_raw = 4'b1010;
        expect_at("repress2", 6, 4'h5, 4'h4, 4'h5, 9'h000, 1'b0);
        tick(6);
        event_clr = 4'b0100;
        expect_at("clr_vs_set", 1, 4'h5, 4'h0, 4'h5, 9'h000, 1'b0);
        tick(1);
        expect_at("clr_alone", 1, 4'h5, 4'h0, 4'h1, 9'h000, 1'b0);
        tick(1);
        event_clr = '0;
        // Release key 0: level drops, no press pulse.
        btn_raw = 4'b1011;
        expect_at("release0_pre", 5, 4'h5, 4'h0, 4'h1, 9'h000, 1'b0);
        expect_at("release0", 6, 4'h4, 4'h0, 4'h1, 9'h000, 1'b0);
        tick(6);
        // All switches on in one cycle.
        sw_raw = 9'h1FF;
        expect_at("sw_pre", 5, 4'h4, 4'h0, 4'h1, 9'h000, 1'b0);
        expect_at("sw_all", 6, 4'h4, 4'h0, 4'h1, 9'h1FF, 1'b1);
        expect_at("sw_post", 7, 4'h4, 4'h0, 4'h1, 9'h1FF, 1'b0);
        tick(7);
        // Switch pattern change together with a key release.
        sw_raw = 9'h0AA; btn_raw = 4'hF;
        expect_at("mixed", 6, 4'h0, 4'h0, 4'h1, 9'h0AA, 1'b1);
        tick(7);
        // Every channel changes at once.
        sw_raw = 9'h155; btn_raw = 4'h0;
        expect_at("all_on", 6, 4'hF, 4'hF, 4'hF, 9'h155, 1'b1);
        expect_at("all_on_post", 7, 4'hF, 4'h0, 4'hF, 9'h155, 1'b0);
        tick(7);
        btn_raw = 4'hF; sw_raw = 9'h000;
        expect_at("all_off", 6, 4'h0, 4'h0, 4'hF, 9'h000, 1'b1);
        tick(7);
        // Reset in the middle of counting a key-3 press, key kept held.
        btn_raw = 4'b0111;
        tick(2);
        reset = 1'b0;
        expect_at("mid_reset", 1, 4'h0, 4'h0, 4'h0, 9'h000, 1'b0);
        tick(2);
        reset = 1'b1;
        expect_at("post_reset_pre", 5, 4'h0, 4'h0, 4'h0, 9'h000, 1'b0);
        expect_at("post_reset", 6, 4'h8, 4'h8, 4'h8, 9'h000, 1'b0);
        expect_at("post_reset_post", 7, 4'h8, 4'h0, 4'h8, 9'h000, 1'b0);
        tick(8);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
